// File: rtl/hpdcache_victim_ctrl.sv
// Victim selection controller: directory read, PLRU replacement request, optional dirty eviction.
// Optional event counters are built when HPDCACHE_VICTIM_CTRL_STATS_EN is defined.
//
// state  | meaning
// IDLE   | ready for a refill-allocation request
// DIR_RD | directory read strobe for the captured set
// SELECT | replacement request; policy victim captured
// EVICT  | dirty write-back eviction outstanding
// RESP   | allocation result presented until consumed
module hpdcache_victim_ctrl #(
   parameter int SETS = 64,
   parameter int WAYS = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [$clog2(SETS)-1:0]  req_set_i,
   input  logic                     req_updt_plru_i,
   output logic                     dir_rd_o,
   output logic [$clog2(SETS)-1:0]  dir_rd_set_o,
   input  logic [WAYS-1:0]          dir_valid_i,
   input  logic [WAYS-1:0]          dir_wb_i,
   input  logic [WAYS-1:0]          dir_dirty_i,
   output logic                     repl_o,
   output logic [$clog2(SETS)-1:0]  repl_set_o,
   output logic [WAYS-1:0]          repl_dir_valid_o,
   output logic [WAYS-1:0]          repl_dir_wb_o,
   output logic [WAYS-1:0]          repl_dir_dirty_o,
   output logic                     repl_updt_plru_o,
   input  logic [WAYS-1:0]          victim_way_i,
   output logic                     evict_valid_o,
   input  logic                     evict_ready_i,
   output logic [$clog2(SETS)-1:0]  evict_set_o,
   output logic [WAYS-1:0]          evict_way_o,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [WAYS-1:0]          rsp_way_o,
   output logic                     rsp_evicted_o,
   output logic                     rsp_novictim_o,
   output logic [31:0]              stat_alloc_o,
   output logic [31:0]              stat_evict_o
);

   typedef enum logic [2:0] {IDLE, DIR_RD, SELECT, EVICT, RESP} state_t;

   state_t                    state;
   logic [$clog2(SETS)-1:0]   set_q;
   logic                      updt_q;
   logic                      dirty_hit;

   assign dirty_hit        = |(victim_way_i & dir_valid_i & dir_wb_i & dir_dirty_i);
   assign dir_rd_set_o     = set_q;
   assign repl_set_o       = set_q;
   assign evict_set_o      = set_q;
   assign repl_updt_plru_o = updt_q;
   assign repl_dir_valid_o = dir_valid_i;
   assign repl_dir_wb_o    = dir_wb_i;
   assign repl_dir_dirty_o = dir_dirty_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         set_q          <= '0;
         updt_q         <= 1'b0;
         req_ready_o    <= 1'b1;
         dir_rd_o       <= 1'b0;
         repl_o         <= 1'b0;
         evict_valid_o  <= 1'b0;
         evict_way_o    <= '0;
         rsp_valid_o    <= 1'b0;
         rsp_way_o      <= '0;
         rsp_evicted_o  <= 1'b0;
         rsp_novictim_o <= 1'b0;
      end else begin
         dir_rd_o <= 1'b0;
         repl_o   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid_i && req_ready_o) begin
                  set_q       <= req_set_i;
                  updt_q      <= req_updt_plru_i;
                  req_ready_o <= 1'b0;
                  dir_rd_o    <= 1'b1;
                  state       <= DIR_RD;
               end
            end
            DIR_RD: begin
               repl_o <= 1'b1;
               state  <= SELECT;
            end
            SELECT: begin
               rsp_way_o   <= victim_way_i;
               evict_way_o <= victim_way_i;
               if (victim_way_i == '0) begin
                  rsp_novictim_o <= 1'b1;
                  rsp_valid_o    <= 1'b1;
                  state          <= RESP;
               end else if (dirty_hit) begin
                  evict_valid_o <= 1'b1;
                  state         <= EVICT;
               end else begin
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end
            end
            EVICT: begin
               if (evict_ready_i) begin
                  evict_valid_o <= 1'b0;
                  rsp_evicted_o <= 1'b1;
                  rsp_valid_o   <= 1'b1;
                  state         <= RESP;
               end
            end
            RESP: begin
               // no bypass: the next request is only accepted once back in IDLE
               if (rsp_ready_i) begin
                  rsp_valid_o    <= 1'b0;
                  rsp_way_o      <= '0;
                  rsp_evicted_o  <= 1'b0;
                  rsp_novictim_o <= 1'b0;
                  req_ready_o    <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HPDCACHE_VICTIM_CTRL_STATS_EN
   logic [31:0] stat_alloc_q;
   logic [31:0] stat_evict_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_alloc_q <= '0;
         stat_evict_q <= '0;
      end else begin
         if (rsp_valid_o && rsp_ready_i && (stat_alloc_q != 32'hFFFF_FFFF))
            stat_alloc_q <= stat_alloc_q + 32'd1;
         if (evict_valid_o && evict_ready_i && (stat_evict_q != 32'hFFFF_FFFF))
            stat_evict_q <= stat_evict_q + 32'd1;
      end
   end

   assign stat_alloc_o = stat_alloc_q;
   assign stat_evict_o = stat_evict_q;
`else
   assign stat_alloc_o = '0;
   assign stat_evict_o = '0;
`endif

   a_victim_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
      repl_o |-> $onehot0(victim_way_i));

endmodule

// File: tb/tb_hpdcache_victim_ctrl.sv
// Directed bench for hpdcache_victim_ctrl; counter checks follow HPDCACHE_VICTIM_CTRL_STATS_EN.
module tb_hpdcache_victim_ctrl;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_ready_o, req_updt_plru_i;
   logic [5:0]  req_set_i, dir_rd_set_o, repl_set_o, evict_set_o;
   logic        dir_rd_o, repl_o, repl_updt_plru_o;
   logic [3:0]  dir_valid_i, dir_wb_i, dir_dirty_i;
   logic [3:0]  repl_dir_valid_o, repl_dir_wb_o, repl_dir_dirty_o;
   logic [3:0]  victim_way_i, evict_way_o, rsp_way_o;
   logic        evict_valid_o, evict_ready_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_evicted_o, rsp_novictim_o;
   logic [31:0] stat_alloc_o, stat_evict_o;

   int checks = 0;
   int fails  = 0;
   int repl_cnt = 0;

   hpdcache_victim_ctrl #(.SETS(64), .WAYS(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_set_i(req_set_i),
      .req_updt_plru_i(req_updt_plru_i),
      .dir_rd_o(dir_rd_o), .dir_rd_set_o(dir_rd_set_o),
      .dir_valid_i(dir_valid_i), .dir_wb_i(dir_wb_i), .dir_dirty_i(dir_dirty_i),
      .repl_o(repl_o), .repl_set_o(repl_set_o),
      .repl_dir_valid_o(repl_dir_valid_o), .repl_dir_wb_o(repl_dir_wb_o),
      .repl_dir_dirty_o(repl_dir_dirty_o), .repl_updt_plru_o(repl_updt_plru_o),
      .victim_way_i(victim_way_i),
      .evict_valid_o(evict_valid_o), .evict_ready_i(evict_ready_i),
      .evict_set_o(evict_set_o), .evict_way_o(evict_way_o),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_way_o(rsp_way_o),
      .rsp_evicted_o(rsp_evicted_o), .rsp_novictim_o(rsp_novictim_o),
      .stat_alloc_o(stat_alloc_o), .stat_evict_o(stat_evict_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) if (repl_o === 1'b1) repl_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // drive a request; returns one cycle after acceptance (DIR_RD cycle)
   task automatic req(input logic [5:0] set, input logic updt, input logic [3:0] v,
                      input logic [3:0] wb, input logic [3:0] d, input logic [3:0] vic);
      req_valid_i = 1'b1; req_set_i = set; req_updt_plru_i = updt;
      dir_valid_i = v; dir_wb_i = wb; dir_dirty_i = d; victim_way_i = vic;
      tick();
      req_valid_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; req_valid_i = 1'b0; req_set_i = '0; req_updt_plru_i = 1'b0;
      dir_valid_i = '0; dir_wb_i = '0; dir_dirty_i = '0; victim_way_i = '0;
      evict_ready_i = 1'b0; rsp_ready_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0;

      // reset state
      chk("rst_req_ready", req_ready_o, 1);
      chk("rst_strobes", {dir_rd_o, repl_o, evict_valid_o, rsp_valid_o}, 0);
      chk("rst_flags", {rsp_way_o, rsp_evicted_o, rsp_novictim_o, evict_way_o}, 0);
      chk("rst_stats", {stat_alloc_o, stat_evict_o}, 0);

      // clean allocation, set 5
      req(6'd5, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      chk("c1_dir_rd", {dir_rd_o, repl_o, req_ready_o}, 3'b100);
      chk("c1_dir_set", dir_rd_set_o, 5);
      tick();
      chk("c2_repl", {repl_o, dir_rd_o, rsp_valid_o}, 3'b100);
      chk("c2_repl_set", repl_set_o, 5);
      chk("c2_updt", repl_updt_plru_o, 1);
      chk("c2_fwd", {repl_dir_valid_o, repl_dir_wb_o, repl_dir_dirty_o}, 0);
      tick();
      chk("c3_rsp", {rsp_valid_o, repl_o, evict_valid_o}, 3'b100);
      chk("c3_rsp_data", {rsp_way_o, rsp_evicted_o, rsp_novictim_o}, {4'b0001, 2'b00});
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      chk("c4_idle", {rsp_valid_o, req_ready_o}, 2'b01);
      chk("c_repl_cnt", repl_cnt, 1);

      // dirty allocation, set 9, eviction stalled
      req(6'd9, 1'b0, 4'b1111, 4'b1111, 4'b0100, 4'b0100);
      tick();
      chk("d2_fwd", {repl_dir_valid_o, repl_dir_wb_o, repl_dir_dirty_o}, 12'hFF4);
      chk("d2_updt", repl_updt_plru_o, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("d_evict_hold", {evict_valid_o, rsp_valid_o, evict_set_o, evict_way_o},
             {2'b10, 6'd9, 4'b0100});
         tick();
      end
      evict_ready_i = 1'b1;
      tick();
      evict_ready_i = 1'b0;
      chk("d_rsp", {rsp_valid_o, evict_valid_o, rsp_evicted_o, rsp_novictim_o}, 4'b1010);
      chk("d_rsp_way", rsp_way_o, 4'b0100);
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      chk("d_repl_cnt", repl_cnt, 2);

      // no victim, response held with request pending
      req(6'd17, 1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
      req_valid_i = 1'b1;
      tick(); tick();
      chk("n_rsp", {rsp_valid_o, evict_valid_o, rsp_novictim_o, rsp_evicted_o}, 4'b1010);
      chk("n_rsp_way", rsp_way_o, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("n_hold", {req_ready_o, rsp_valid_o, rsp_novictim_o, rsp_way_o, evict_valid_o},
             {3'b011, 4'b0000, 1'b0});
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      chk("n_idle", {req_ready_o, rsp_valid_o, rsp_novictim_o}, 3'b100);
      chk("n_repl_cnt", repl_cnt, 3);

      // reset during EVICT, then a normal request
      req(6'd33, 1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b1000);
      tick(); tick();
      chk("r_in_evict", {evict_valid_o, evict_way_o}, 5'b11000);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("r_outputs", {dir_rd_o, repl_o, evict_valid_o, rsp_valid_o, rsp_way_o,
                        rsp_evicted_o, rsp_novictim_o, evict_way_o, evict_set_o}, 0);
      chk("r_ready", req_ready_o, 1);
      tick(); tick();
      chk("r_no_rsp", {rsp_valid_o, evict_valid_o}, 0);
      req(6'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
      tick(); tick();
      chk("r_next_rsp", {rsp_valid_o, rsp_way_o, rsp_evicted_o}, {1'b1, 4'b0010, 1'b0});
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      chk("r_repl_cnt", repl_cnt, 5);

      // two more allocations after the reset: one dirty, one clean
      req(6'd40, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
      tick(); tick();
      evict_ready_i = 1'b1;
      tick();
      evict_ready_i = 1'b0;
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      req(6'd41, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      tick(); tick();
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
`ifdef HPDCACHE_VICTIM_CTRL_STATS_EN
      chk("s_alloc", stat_alloc_o, 3);
      chk("s_evict", stat_evict_o, 1);
      force dut.stat_alloc_q = 32'hFFFF_FFFF;
      tick();
      release dut.stat_alloc_q;
      req(6'd42, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      tick(); tick();
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      chk("s_alloc_sat", stat_alloc_o, 32'hFFFF_FFFF);
      chk("s_evict_keep", stat_evict_o, 1);
`else
      chk("s_alloc_tied", stat_alloc_o, 0);
      chk("s_evict_tied", stat_evict_o, 0);
`endif
      chk("end_idle", {req_ready_o, rsp_valid_o, evict_valid_o}, 3'b100);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/hpdcache_victim_ctrl.md
Name: hpdcache_victim_ctrl

Overview:
- Initiator side of the replacement-policy interface.
- Accepts refill-allocation requests from the miss handler, then reads the directory for the target set.
- Issues exactly one replacement request per allocation to the PLRU policy and captures the victim way.
- If the victim holds dirty write-back data, requests an eviction and waits for the ack before returning the allocated way.

Parameters:
- SETS, 64: sets per cache; set index width is $clog2(SETS).
- WAYS, 4: ways per set; width of all way vectors.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  allocation request valid.
- req_ready_o  out  1  request accepted when valid and ready are both high.
- req_set_i  in  $clog2(SETS)  target set.
- req_updt_plru_i  in  1  update PLRU state on replacement.
- dir_rd_o  out  1  directory read strobe.
- dir_rd_set_o  out  $clog2(SETS)  directory read set.
- dir_valid_i, dir_wb_i, dir_dirty_i  in  WAYS each  directory state, valid exactly 1 cycle after dir_rd_o.
- repl_o  out  1  replacement request to the policy, 1-cycle pulse.
- repl_set_o  out  $clog2(SETS)  replacement set.
- repl_dir_valid_o, repl_dir_wb_o, repl_dir_dirty_o  out  WAYS each  directory state forwarded to the policy.
- repl_updt_plru_o  out  1  PLRU update enable.
- victim_way_i  in  WAYS  one-hot victim from the policy, combinational on repl_* inputs.
- evict_valid_o  out  1  dirty eviction request.
- evict_ready_i  in  1  eviction accepted.
- evict_set_o  out  $clog2(SETS)  eviction set.
- evict_way_o  out  WAYS  eviction way.
- rsp_valid_o  out  1  allocation result valid.
- rsp_ready_i  in  1  result consumed.
- rsp_way_o  out  WAYS  allocated way.
- rsp_evicted_o  out  1  a dirty eviction was performed.
- rsp_novictim_o  out  1  no allocatable way.
- stat_alloc_o  out  32  allocation counter (see Optional Feature).
- stat_evict_o  out  32  eviction counter (see Optional Feature).

Behaviour:
- FSM states: IDLE, DIR_RD, SELECT, EVICT, RESP.
- Reset values: state=IDLE. All valid, strobe and pulse outputs are 0. All registered set, way and flag outputs are 0. req_ready_o=1 after reset.
- IDLE:
  - req_ready_o=1 only in this state.
  - On handshake, register req_set_i and req_updt_plru_i, then go to DIR_RD.
- DIR_RD:
  - dir_rd_o=1 for exactly one cycle with dir_rd_set_o = registered set.
  - Go to SELECT.
- SELECT:
  - repl_o=1 for exactly one cycle.
  - repl_set_o = registered set; repl_dir_* = dir_*_i passed through combinationally; repl_updt_plru_o = registered flag.
  - Register victim_way_i. Compute dirty_hit = |(victim_way_i & dir_valid_i & dir_wb_i & dir_dirty_i).
  - victim_way_i == 0: rsp_novictim_o=1, rsp_way_o=0, go to RESP.
  - dirty_hit=1: go to EVICT.
  - Otherwise: go to RESP.
- EVICT:
  - evict_valid_o=1, evict_set_o and evict_way_o held stable until evict_ready_i.
  - On the handshake cycle, set rsp_evicted_o=1 and go to RESP.
  - evict_ready_i is ignored outside EVICT.
- RESP:
  - rsp_valid_o=1 with rsp_way_o/rsp_evicted_o/rsp_novictim_o stable until rsp_ready_i.
  - On handshake, clear the flags and go to IDLE.
  - No new request is accepted in the same cycle (no bypass).
- Latency: clean allocation accepted at cycle 0 gives repl_o at cycle 2 and rsp_valid_o at cycle 3. A dirty allocation adds at least 1 cycle plus the evict_ready_i stall.
- dir_*_i are sampled only in SELECT; values in other states are don't-care.
- Exactly one repl_o pulse per accepted request. repl_o and dir_rd_o are never high in the same cycle.
- rst_i asserted in any state: next cycle is IDLE, all outputs at reset values, and no repl_o, evict_valid_o or rsp_valid_o is issued for the aborted request.
- Simulation assertion: victim_way_i is one-hot or zero when repl_o=1.

Optional Feature:
- Macro: HPDCACHE_VICTIM_CTRL_STATS_EN.
- Defined:
  - stat_alloc_o increments on each rsp handshake.
  - stat_evict_o increments on each evict handshake.
  - Both counters are 32-bit, saturate at 0xFFFFFFFF, and clear on rst_i.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset, then request set 5 with dir_valid=4'b0000 and policy victim 4'b0001 -> dir_rd_o at cycle 1, repl_o at cycle 2, rsp_valid_o at cycle 3 with rsp_way_o=4'b0001, rsp_evicted_o=0.
- Set 9, all valid, dirty=4'b0100, wb=4'b1111, victim 4'b0100 -> evict_valid_o with evict_set_o=9 and evict_way_o=4'b0100; evict_ready_i held 0 for 5 cycles keeps it stable; after ack, rsp_evicted_o=1.
- victim_way_i=4'b0000 in SELECT -> rsp_novictim_o=1, rsp_way_o=0, no evict_valid_o.
- rsp_ready_i=0 for 4 cycles with req_valid_i=1 -> req_ready_o stays 0, rsp outputs stable; a single repl_o pulse is seen per request.
- rst_i asserted while in EVICT -> next cycle all outputs 0, req_ready_o=1, and the next request completes normally.
- With stats enabled: 3 allocations, 1 of them dirty -> stat_alloc_o=3, stat_evict_o=1; forcing the counter to 0xFFFFFFFF -> it holds after a further allocation.
